// File: rtl/ibex_pkg.sv
// rtl/ibex_pkg.sv - shared types for the register file write-port sequencer
package ibex_pkg;

  typedef enum logic {
    RF_SEQ_CLEAR = 1'b0,
    RF_SEQ_RUN   = 1'b1
  } rf_seq_state_e;

endpackage

// File: rtl/ibex_rf_wr_sequencer.sv
// rtl/ibex_rf_wr_sequencer.sv - sequences clear sweep, core writeback and debug writes onto the rf write port
module ibex_rf_wr_sequencer
  import ibex_pkg::*;
#(
  parameter bit                   RV32E        = 1'b0,
  parameter int unsigned          DataWidth    = 32,
  parameter logic [DataWidth-1:0] WordClearVal = '0,
  parameter bit                   ClearOnReset = 1'b1,
  parameter int unsigned          StarveLimit  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_req_i,
  output logic                 busy_o,
  output logic                 clear_done_o,
  input  logic                 core_we_i,
  input  logic [4:0]           core_waddr_i,
  input  logic [DataWidth-1:0] core_wdata_i,
  output logic                 core_ready_o,
  input  logic                 dbg_req_i,
  input  logic [4:0]           dbg_waddr_i,
  input  logic [DataWidth-1:0] dbg_wdata_i,
  output logic                 dbg_gnt_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o
);

  localparam int unsigned NUM_WORDS    = RV32E ? 16 : 32;
  localparam int unsigned ADDR_WIDTH   = $clog2(NUM_WORDS);
  localparam int unsigned STARVE_WIDTH = $clog2(StarveLimit + 1);

  localparam logic [ADDR_WIDTH-1:0]   LAST_ADDR  = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0]   FIRST_ADDR = ADDR_WIDTH'(1);
  localparam logic [STARVE_WIDTH-1:0] STARVE_MAX = STARVE_WIDTH'(StarveLimit);

  rf_seq_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0]     cnt_q, cnt_d;
  logic [STARVE_WIDTH-1:0]   starve_q, starve_d;

  logic                 forced;
  logic                 wr_en;
  logic [4:0]           wr_addr;
  logic [DataWidth-1:0] wr_data;

  assign forced = dbg_req_i && (starve_q == STARVE_MAX);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ClearOnReset ? RF_SEQ_CLEAR : RF_SEQ_RUN;
      cnt_q    <= FIRST_ADDR;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    starve_d     = starve_q;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    busy_o       = 1'b0;
    clear_done_o = 1'b0;
    core_ready_o = 1'b0;
    dbg_gnt_o    = 1'b0;

    unique case (state_q)
      RF_SEQ_CLEAR: begin
        busy_o  = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 5'(cnt_q);
        wr_data = WordClearVal;
        if (cnt_q == LAST_ADDR) begin
          clear_done_o = 1'b1;
          state_d      = RF_SEQ_RUN;
          cnt_d        = FIRST_ADDR;
        end else begin
          cnt_d = cnt_q + FIRST_ADDR;
        end
      end
      RF_SEQ_RUN: begin
        if (clear_req_i) begin
          state_d = RF_SEQ_CLEAR;
          cnt_d   = FIRST_ADDR;
        end else if (forced) begin
          dbg_gnt_o = 1'b1;
          wr_en     = 1'b1;
          wr_addr   = dbg_waddr_i;
          wr_data   = dbg_wdata_i;
        end else begin
          core_ready_o = 1'b1;
          if (core_we_i) begin
            wr_en   = 1'b1;
            wr_addr = core_waddr_i;
            wr_data = core_wdata_i;
          end else if (dbg_req_i) begin
            dbg_gnt_o = 1'b1;
            wr_en     = 1'b1;
            wr_addr   = dbg_waddr_i;
            wr_data   = dbg_wdata_i;
          end
        end
      end
      default: ;
    endcase

    // Saturate so a clear request landing on the limit cycle cannot overflow the counter.
    if (!dbg_req_i || dbg_gnt_o) begin
      starve_d = '0;
    end else if (state_q == RF_SEQ_RUN && core_we_i && starve_q != STARVE_MAX) begin
      starve_d = starve_q + STARVE_WIDTH'(1);
    end

    rf_we_o    = wr_en && (wr_addr != 5'd0);
    rf_waddr_o = wr_addr;
    rf_wdata_o = wr_data;

    if (rst_i) begin
      rf_we_o      = 1'b0;
      rf_waddr_o   = '0;
      rf_wdata_o   = '0;
      core_ready_o = 1'b0;
      dbg_gnt_o    = 1'b0;
      clear_done_o = 1'b0;
      busy_o       = 1'b1;
    end
  end

endmodule

// File: tb/tb_ibex_rf_wr_sequencer.sv
// tb/tb_ibex_rf_wr_sequencer.sv - randomized bench for ibex_rf_wr_sequencer against a behavioural model
module tb_ibex_rf_wr_sequencer;

  localparam int          NW    = 32;
  localparam int          LIMIT = 4;
  localparam logic [31:0] CLR   = 32'hA5C3_0F69;

  logic        clk = 1'b0;
  logic        rst, clear_req, core_we, dbg_req;
  logic [4:0]  core_waddr, dbg_waddr;
  logic [31:0] core_wdata, dbg_wdata;
  logic        busy, clear_done, core_ready, dbg_gnt, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: sweeping flag, next sweep address, count of denied debug cycles.
  bit m_sweep;
  int m_idx;
  int m_starve;

  // Expected outputs for the current cycle.
  bit          e_busy, e_done, e_ready, e_gnt, e_write, e_we;
  logic [4:0]  e_addr;
  logic [31:0] e_data;

  int sweep_writes;
  int gnt_cycle;
  int cyc;

  always #5 clk = ~clk;

  ibex_rf_wr_sequencer #(
    .RV32E(1'b0), .DataWidth(32), .WordClearVal(CLR), .ClearOnReset(1'b1), .StarveLimit(LIMIT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .clear_req_i(clear_req), .busy_o(busy), .clear_done_o(clear_done),
    .core_we_i(core_we), .core_waddr_i(core_waddr), .core_wdata_i(core_wdata), .core_ready_o(core_ready),
    .dbg_req_i(dbg_req), .dbg_waddr_i(dbg_waddr), .dbg_wdata_i(dbg_wdata), .dbg_gnt_o(dbg_gnt),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_eval();
    e_busy = 0; e_done = 0; e_ready = 0; e_gnt = 0; e_write = 0; e_addr = '0; e_data = '0;
    if (rst) begin
      e_busy = 1;
    end else if (m_sweep) begin
      e_busy = 1; e_write = 1; e_addr = 5'(m_idx); e_data = CLR;
      e_done = (m_idx == NW - 1);
    end else if (clear_req) begin
      // clear request wins: nothing written, nothing acknowledged
    end else if (dbg_req && m_starve >= LIMIT) begin
      e_gnt = 1; e_write = 1; e_addr = dbg_waddr; e_data = dbg_wdata;
    end else begin
      e_ready = 1;
      if (core_we) begin
        e_write = 1; e_addr = core_waddr; e_data = core_wdata;
      end else if (dbg_req) begin
        e_gnt = 1; e_write = 1; e_addr = dbg_waddr; e_data = dbg_wdata;
      end
    end
    e_we = e_write && (e_addr != 0);
  endtask

  task automatic model_update();
    if (rst) begin
      m_sweep = 1; m_idx = 1; m_starve = 0;
    end else begin
      if (!dbg_req || e_gnt) m_starve = 0;
      else if (!m_sweep && core_we && m_starve < LIMIT) m_starve++;
      if (m_sweep) begin
        if (m_idx == NW - 1) begin m_sweep = 0; m_idx = 1; end
        else m_idx++;
      end else if (clear_req) begin
        m_sweep = 1; m_idx = 1;
      end
    end
  endtask

  // Inputs are applied just after a rising edge; outputs are checked on the falling edge.
  task automatic step();
    @(negedge clk);
    model_eval();
    check("busy", 64'(busy), 64'(e_busy));
    check("clear_done", 64'(clear_done), 64'(e_done));
    check("core_ready", 64'(core_ready), 64'(e_ready));
    check("dbg_gnt", 64'(dbg_gnt), 64'(e_gnt));
    check("rf_we", 64'(rf_we), 64'(e_we));
    if (e_write || rst) begin
      check("rf_waddr", 64'(rf_waddr), 64'(e_addr));
      check("rf_wdata", 64'(rf_wdata), 64'(e_data));
    end
    if (!rst && busy && rf_we) sweep_writes++;
    if (dbg_gnt && gnt_cycle < 0) gnt_cycle = cyc;
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    clear_req = 0; core_we = 0; dbg_req = 0;
    core_waddr = '0; core_wdata = '0; dbg_waddr = '0; dbg_wdata = '0;
  endtask

  initial begin
    cyc = 0; gnt_cycle = -1; sweep_writes = 0;
    m_sweep = 1; m_idx = 1; m_starve = 0;
    idle_inputs();
    rst = 1;
    #1;
    repeat (3) step();
    rst = 0;

    // Reset-release sweep, then a few idle RUN cycles.
    sweep_writes = 0;
    repeat (NW + 2) step();
    check("sweep_len", 64'(sweep_writes), 64'(NW - 1));

    // Plain core write.
    core_we = 1; core_waddr = 5; core_wdata = 32'hDEADBEEF;
    step();
    idle_inputs();

    // Debug write alone.
    dbg_req = 1; dbg_waddr = 7; dbg_wdata = 32'h1234;
    step();
    idle_inputs();

    // Core and debug held together: debug forced through on cycle LIMIT.
    core_we = 1; core_waddr = 9; core_wdata = 32'h0BAD_CAFE;
    dbg_req = 1; dbg_waddr = 11; dbg_wdata = 32'h5555_AAAA;
    gnt_cycle = -1;
    begin
      int start;
      start = cyc;
      repeat (LIMIT + 1) step();
      check("dbg_latency", 64'(gnt_cycle - start), 64'(LIMIT));
    end
    dbg_req = 0;
    step();
    idle_inputs();

    // Core write to r0: acknowledged, not written.
    core_we = 1; core_waddr = 0; core_wdata = 32'hFFFF_FFFF;
    step();
    idle_inputs();

    // Clear request during a held core write.
    core_we = 1; core_waddr = 13; core_wdata = 32'h1357_9BDF;
    clear_req = 1;
    step();
    clear_req = 0;
    repeat (NW) step();
    idle_inputs();
    step();

    // Reset in the middle of a sweep.
    clear_req = 1;
    step();
    clear_req = 0;
    repeat (9) step();
    check("mid_sweep_addr", 64'(m_idx), 64'(10));
    rst = 1;
    repeat (2) step();
    rst = 0;
    repeat (NW + 1) step();

    // Randomized traffic with the core and debug hold rules honoured.
    for (int i = 0; i < 3000; i++) begin
      bit hold_core, hold_dbg;
      hold_core = core_we && !e_ready;
      hold_dbg  = dbg_req && !e_gnt;
      if (!hold_core) begin
        core_we    = ($urandom_range(3) != 0);
        core_waddr = 5'($urandom_range(31));
        core_wdata = $urandom;
      end
      if (!hold_dbg) begin
        dbg_req   = ($urandom_range(2) == 0);
        dbg_waddr = 5'($urandom_range(31));
        dbg_wdata = $urandom;
      end
      clear_req = ($urandom_range(63) == 0);
      rst       = ($urandom_range(499) == 0);
      step();
    end
    rst = 0;
    idle_inputs();
    repeat (NW + 2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
